id_ex_bubble_reg: RTL
=====================

// Module: id_ex_bubble_reg
// PURPOSE
//  ID/EX pipeline register; the consuming end of the load-use hazard unit's stall/bubble
//  outputs. PC/IF-ID hold is done elsewhere; this block turns the bubble request into a NOP.
//  Per cycle: load the decoded instruction, hold it (stall), replace it with a NOP (bubble),
//  or kill it (flush on taken branch).
//  Also counts bubbles/flushes and flags runaway hazard stalls. Sits between decode and ALU.
// PARAMETERS
//  XLEN        32  datapath width of pc/rs1_data/rs2_data/imm
//  CNT_W       16  width of bubble/flush event counters (saturating)
//  MAX_BUBBLE  2   max consecutive bubble cycles before hazard_err sets
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      reset, synchronous, active-low
//  bubble_in     in   1      1 = insert NOP this cycle (load-use hazard)
//  flush_in      in   1      1 = kill instruction entering EX (branch taken)
//  stall_in      in   1      1 = EX not advancing, hold all contents
//  id_valid      in   1      decode slot holds a real instruction
//  id_pc         in   XLEN   PC of decoded instruction
//  id_rs1_data   in   XLEN   register-file read port 1
//  id_rs2_data   in   XLEN   register-file read port 2
//  id_imm        in   XLEN   sign-extended immediate
//  id_rs1/id_rs2/id_rd in 5  register indices
//  id_ctrl       in   9      {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,Branch,Jump,ALUOp[1:0]}
//  ex_valid      out  1      EX slot holds a real instruction
//  ex_pc/ex_rs1_data/ex_rs2_data/ex_imm out XLEN  registered copies
//  ex_rs1/ex_rs2/ex_rd out 5 registered indices (to forwarding unit)
//  ex_ctrl       out  9      registered control word
//  bubble_cnt    out  CNT_W  bubbles inserted since reset
//  flush_cnt     out  CNT_W  flushes performed since reset
//  hazard_err    out  1      sticky: bubble_in held > MAX_BUBBLE consecutive cycles
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): all ex_* = 0 (NOP), ex_valid=0, counters=0, hazard_err=0,
//    FSM=IDLE. Reset overrides all inputs. Mid-stall reset drops the held instruction.
//  - Latency 1 cycle. Per-edge priority: flush > stall > bubble > load.
//    flush : ex_valid=0, ex_ctrl=0, ex_rd=0; data fields don't-care (drive 0); flush_cnt++.
//    stall : all ex_* hold; counters and FSM hold.
//    bubble: ex_valid=0, ex_ctrl=0, ex_rd=0, ex_rs1=ex_rs2=0; bubble_cnt++.
//    load  : ex_* <= id_*; ex_valid <= id_valid; id_valid=0 forces ex_ctrl=0.
//  - A NOP always has RegWrite=MemWrite=MemRead=Branch=Jump=0, so it cannot write state.
//  - Counters saturate at 2^CNT_W-1, no wrap. flush+bubble same cycle: only flush_cnt counts.
//  - FSM (bubble watchdog), run-length counter RUN (width clog2(MAX_BUBBLE+2)):
//    IDLE   : bubble applied -> BUBBLE, RUN=1.
//    BUBBLE : bubble applied -> RUN++; RUN would exceed MAX_BUBBLE -> ERR, hazard_err=1.
//             Load or flush -> IDLE, RUN=0.
//    ERR    : hazard_err stays 1; only reset clears it. Pipeline keeps operating normally.
//    Stall cycles never advance or clear the FSM.
// STRUCTURE
//  - Shared pkg: CTRL_W=9, ctrl bit index localparams (CTRL_REGWRITE..CTRL_ALUOP),
//    NOP_CTRL=9'b0, FSM state encodings.
//  - Single module; the saturating counter is a natural sub-module (sat_counter #(CNT_W)),
//    instantiated twice.
// TESTING
//  1 rst_n=0 two cycles with id_* random -> all ex_*=0, ex_valid=0, counters 0, hazard_err=0.
//  2 load id_pc=0x100,id_rd=5,id_ctrl=9'h181 -> next cycle ex_pc=0x100, ex_rd=5, ex_valid=1.
//  3 bubble_in=1 for 1 cycle -> ex_ctrl=0, ex_valid=0, bubble_cnt=1; next load restores.
//  4 bubble_in=1 and flush_in=1 same cycle -> NOP, flush_cnt=1, bubble_cnt=0.
//  5 stall_in=1 3 cycles with bubble_in=1 -> ex_* unchanged, bubble_cnt unchanged, FSM holds.
//  6 bubble_in=1 for 3 cycles (MAX_BUBBLE=2) -> hazard_err=1 after 3rd edge; stays 1 until
//    rst_n=0.

Source files
------------

// File: rtl/id_ex_bubble_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-word layout,
// the NOP control word, bubble-watchdog states and per-cycle slot actions.
package id_ex_bubble_reg_pkg;

  // Control word: {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,Branch,Jump,ALUOp[1:0]}
  localparam int CTRL_W        = 9;
  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMREAD  = 7;
  localparam int CTRL_MEMWRITE = 6;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_BRANCH   = 3;
  localparam int CTRL_JUMP     = 2;
  localparam int CTRL_ALUOP    = 0;  // LSB of the two-bit ALUOp field
  localparam int CTRL_ALUOP_W  = 2;

  // Register index width (x0..x31)
  localparam int REG_IDX_W = 5;

  // All-zero control word: no register write, no memory access, no branch/jump.
  localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

  // Bubble watchdog states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_ERR    = 2'd2
  } wd_state_e;

  // What the EX slot does on the coming edge
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_STALL  = 2'd2,
    ACT_FLUSH  = 2'd3
  } slot_act_e;

  // Resolve the three request lines with priority flush > stall > bubble > load.
  function automatic slot_act_e pick_action(input logic flush, input logic stall,
                                            input logic bubble);
    slot_act_e act;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (stall) begin
      act = ACT_STALL;
    end else if (bubble) begin
      act = ACT_BUBBLE;
    end else begin
      act = ACT_LOAD;
    end
    return act;
  endfunction

  // An instruction that is not valid must never carry live control bits.
  function automatic logic [CTRL_W-1:0] gate_ctrl(input logic valid,
                                                  input logic [CTRL_W-1:0] ctrl);
    return valid ? ctrl : NOP_CTRL;
  endfunction

  // True when a control word could change architectural state.
  function automatic logic ctrl_has_side_effect(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_REGWRITE] | ctrl[CTRL_MEMREAD] | ctrl[CTRL_MEMWRITE] |
           ctrl[CTRL_BRANCH]   | ctrl[CTRL_JUMP];
  endfunction

endpackage

// File: rtl/id_ex_bubble_reg_sat_counter.sv
// Saturating event counter: counts qualified events from reset and sticks at
// all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = &r_count;

  // Count one event per qualified cycle; hold once the maximum is reached.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/id_ex_bubble_reg.sv
// ID/EX pipeline register. Each edge the EX slot either loads the decoded
// instruction, holds (stall), becomes a NOP (load-use bubble) or is killed
// (branch flush). Bubble and flush events are counted, and a watchdog flags
// bubble requests that persist for too many consecutive applied cycles.
module id_ex_bubble_reg
  import id_ex_bubble_reg_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CNT_W      = 16,
  parameter int MAX_BUBBLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bubble_in,
  input  logic                 flush_in,
  input  logic                 stall_in,
  input  logic                 id_valid,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [XLEN-1:0]      id_rs1_data,
  input  logic [XLEN-1:0]      id_rs2_data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic [4:0]           id_rd,
  input  logic [8:0]           id_ctrl,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      ex_pc,
  output logic [XLEN-1:0]      ex_rs1_data,
  output logic [XLEN-1:0]      ex_rs2_data,
  output logic [XLEN-1:0]      ex_imm,
  output logic [4:0]           ex_rs1,
  output logic [4:0]           ex_rs2,
  output logic [4:0]           ex_rd,
  output logic [8:0]           ex_ctrl,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic                 hazard_err
);

  // Run-length counter must hold MAX_BUBBLE+1 without overflowing.
  localparam int RUN_W = $clog2(MAX_BUBBLE + 2);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_BUBBLE);

  // Event counter indices
  localparam int EV_BUBBLE = 0;
  localparam int EV_FLUSH  = 1;
  localparam int EV_NUM    = 2;

  // ------------------------------------------------------------------
  // Slot action decode
  // ------------------------------------------------------------------
  slot_act_e w_action;
  logic      w_bubble_applied;
  logic      w_advance;

  assign w_action         = pick_action(flush_in, stall_in, bubble_in);
  assign w_bubble_applied = (w_action == ACT_BUBBLE);
  // Load or flush both move a new (possibly dead) instruction into EX.
  assign w_advance        = (w_action == ACT_LOAD) || (w_action == ACT_FLUSH);

  // ------------------------------------------------------------------
  // EX slot registers
  // ------------------------------------------------------------------
  logic                 r_ex_valid;
  logic [XLEN-1:0]      r_ex_pc;
  logic [XLEN-1:0]      r_ex_rs1_data;
  logic [XLEN-1:0]      r_ex_rs2_data;
  logic [XLEN-1:0]      r_ex_imm;
  logic [REG_IDX_W-1:0] r_ex_rs1;
  logic [REG_IDX_W-1:0] r_ex_rs2;
  logic [REG_IDX_W-1:0] r_ex_rd;
  logic [CTRL_W-1:0]    r_ex_ctrl;

  // Update the EX slot: NOP on reset/bubble/flush, hold on stall, else load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_pc       <= '0;
      r_ex_rs1_data <= '0;
      r_ex_rs2_data <= '0;
      r_ex_imm      <= '0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_rd       <= '0;
      r_ex_ctrl     <= NOP_CTRL;
    end else begin
      unique case (w_action)
        ACT_FLUSH, ACT_BUBBLE: begin
          // Killed/inserted slot: zero everything so forwarding never sees
          // stale register indices and no side effect can escape.
          r_ex_valid    <= 1'b0;
          r_ex_pc       <= '0;
          r_ex_rs1_data <= '0;
          r_ex_rs2_data <= '0;
          r_ex_imm      <= '0;
          r_ex_rs1      <= '0;
          r_ex_rs2      <= '0;
          r_ex_rd       <= '0;
          r_ex_ctrl     <= NOP_CTRL;
        end
        ACT_LOAD: begin
          r_ex_valid    <= id_valid;
          r_ex_pc       <= id_pc;
          r_ex_rs1_data <= id_rs1_data;
          r_ex_rs2_data <= id_rs2_data;
          r_ex_imm      <= id_imm;
          r_ex_rs1      <= id_rs1;
          r_ex_rs2      <= id_rs2;
          r_ex_rd       <= id_rd;
          r_ex_ctrl     <= gate_ctrl(id_valid, id_ctrl);
        end
        default: begin
          // ACT_STALL: hold every field
        end
      endcase
    end
  end

  assign ex_valid    = r_ex_valid;
  assign ex_pc       = r_ex_pc;
  assign ex_rs1_data = r_ex_rs1_data;
  assign ex_rs2_data = r_ex_rs2_data;
  assign ex_imm      = r_ex_imm;
  assign ex_rs1      = r_ex_rs1;
  assign ex_rs2      = r_ex_rs2;
  assign ex_rd       = r_ex_rd;
  assign ex_ctrl     = r_ex_ctrl;

  // ------------------------------------------------------------------
  // Bubble / flush event counters
  // ------------------------------------------------------------------
  logic             w_cnt_inc [EV_NUM];
  logic [CNT_W-1:0] w_cnt     [EV_NUM];

  // A bubble coinciding with a flush resolves to a flush, so only one
  // counter ever steps per edge.
  assign w_cnt_inc[EV_BUBBLE] = w_bubble_applied;
  assign w_cnt_inc[EV_FLUSH]  = (w_action == ACT_FLUSH);

  generate
    for (genvar gi = 0; gi < EV_NUM; gi++) begin : g_evt_cnt
      sat_counter #(
        .W (CNT_W)
      ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_cnt_inc[gi]),
        .o_count (w_cnt[gi])
      );
    end
  endgenerate

  assign bubble_cnt = w_cnt[EV_BUBBLE];
  assign flush_cnt  = w_cnt[EV_FLUSH];

  // ------------------------------------------------------------------
  // Bubble watchdog FSM
  // ------------------------------------------------------------------
  wd_state_e        r_state;
  wd_state_e        w_state_next;
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] w_run_next;
  logic [RUN_W-1:0] w_run_inc;

  assign w_run_inc = r_run + RUN_ONE;

  // Watchdog state and run-length registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_run   <= '0;
    end else begin
      r_state <= w_state_next;
      r_run   <= w_run_next;
    end
  end

  // Next-state logic; stall cycles fall through every branch and hold.
  always_comb begin
    w_state_next = r_state;
    w_run_next   = r_run;
    unique case (r_state)
      ST_IDLE: begin
        if (w_bubble_applied) begin
          w_run_next   = RUN_ONE;
          w_state_next = (RUN_ONE > RUN_MAX) ? ST_ERR : ST_BUBBLE;
        end
      end
      ST_BUBBLE: begin
        if (w_bubble_applied) begin
          w_run_next = w_run_inc;
          if (w_run_inc > RUN_MAX) begin
            w_state_next = ST_ERR;
          end
        end else if (w_advance) begin
          w_state_next = ST_IDLE;
          w_run_next   = '0;
        end
      end
      ST_ERR: begin
        // Sticky until reset; pipeline keeps running regardless.
      end
      default: begin
        w_state_next = ST_IDLE;
        w_run_next   = '0;
      end
    endcase
  end

  assign hazard_err = (r_state == ST_ERR);

endmodule
